// File: rtl/univ_shift_reg.sv
// Universal shift register: load, shifts, rotates and an LSB-first serialise burst.
// Build option: define USHIFT_PARITY_EN to drive parity with the even-parity bit of d_out.
`timescale 1ns/1ps

module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic             start,
    output logic [WIDTH-1:0] d_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           stateQ, stateD;
    logic [WIDTH-1:0] dataQ, dataD;
    logic [CW-1:0]    countQ, countD;
    logic             busyQ, busyD;
    logic             doneQ, doneD;

    // Next-state logic: start wins over mode ops in IDLE, and BURST ignores every control input.
    always_comb begin
        stateD = stateQ;
        dataD  = dataQ;
        countD = countQ;
        busyD  = busyQ;
        doneD  = 1'b0;
        case (stateQ)
            IDLE: begin
                if (start) begin
                    dataD  = d_in;
                    countD = CW'(WIDTH - 1);
                    busyD  = 1'b1;
                    stateD = BURST;
                end else if (en) begin
                    case (mode)
                        3'b000: dataD = dataQ;
                        3'b001: dataD = d_in;
                        3'b010: dataD = {ser_in_r, dataQ[WIDTH-1:1]};
                        3'b011: dataD = {dataQ[WIDTH-2:0], ser_in_l};
                        3'b100: dataD = {dataQ[0], dataQ[WIDTH-1:1]};
                        3'b101: dataD = {dataQ[WIDTH-2:0], dataQ[WIDTH-1]};
                        3'b110: dataD = {dataQ[WIDTH-1], dataQ[WIDTH-1:1]};
                        default: dataD = '0;
                    endcase
                end
            end
            BURST: begin
                // The final shift empties the register, so it returns to IDLE holding zero.
                dataD = {1'b0, dataQ[WIDTH-1:1]};
                if (countQ != '0) begin
                    countD = countQ - CW'(1);
                    doneD  = (countQ == CW'(1));
                end else begin
                    busyD  = 1'b0;
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
            dataQ  <= '0;
            countQ <= '0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            dataQ  <= dataD;
            countQ <= countD;
            busyQ  <= busyD;
            doneQ  <= doneD;
        end
    end

    assign d_out     = dataQ;
    assign ser_out_r = dataQ[0];
    assign ser_out_l = dataQ[WIDTH-1];
    assign busy      = busyQ;
    assign done      = doneQ;

`ifdef USHIFT_PARITY_EN
    assign parity = ^dataQ;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg (WIDTH=8): directed steps plus random traffic against an arithmetic model.
`timescale 1ns/1ps

module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic [W-1:0] d_in = '0;
    logic         ser_in_r = 1'b0;
    logic         ser_in_l = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] d_out;
    logic         ser_out_r, ser_out_l, busy, done, parity;

    int testCount = 0;
    int failCount = 0;

    // Reference state: register value as an integer, burst flag, burst bit index and captured word.
    int mData = 0;
    int mBusy = 0;
    int mK = 0;
    int mWord = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d_in(d_in),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .start(start),
        .d_out(d_out), .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
        .busy(busy), .done(done), .parity(parity)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int expParity(input int v);
        int p = 0;
`ifdef USHIFT_PARITY_EN
        for (int i = 0; i < W; i++) p ^= (v >> i) & 1;
`endif
        return p;
    endfunction

    task automatic checkOutput(input string tag);
        checkValue({tag, ".d_out"}, 64'(d_out), 64'(mData));
        checkValue({tag, ".busy"}, 64'(busy), 64'(mBusy));
        checkValue({tag, ".done"}, 64'(done), 64'((mBusy != 0 && mK == W - 1) ? 1 : 0));
        checkValue({tag, ".ser_out_r"}, 64'(ser_out_r), 64'(mData % 2));
        checkValue({tag, ".ser_out_l"}, 64'(ser_out_l), 64'(mData / (1 << (W - 1))));
        checkValue({tag, ".parity"}, 64'(parity), 64'(expParity(mData)));
        if (mBusy != 0)
            checkValue({tag, ".burst_bit"}, 64'(ser_out_r), 64'((mWord >> mK) & 1));
    endtask

    task automatic modelReset();
        mData = 0;
        mBusy = 0;
        mK = 0;
    endtask

    // Advance the model by one edge from the inputs currently applied.
    task automatic modelTick();
        int top = 1 << (W - 1);
        if (mBusy != 0) begin
            mData = mData / 2;
            if (mK == W - 1) mBusy = 0;
            else mK++;
        end else if (start) begin
            mData = int'(d_in);
            mWord = int'(d_in);
            mBusy = 1;
            mK = 0;
        end else if (en) begin
            case (mode)
                3'd1: mData = int'(d_in);
                3'd2: mData = mData / 2 + (ser_in_r ? top : 0);
                3'd3: mData = (mData * 2) % (1 << W) + (ser_in_l ? 1 : 0);
                3'd4: mData = mData / 2 + ((mData % 2) * top);
                3'd5: mData = (mData * 2) % (1 << W) + mData / top;
                3'd6: mData = mData / 2 + (mData >= top ? top : 0);
                3'd7: mData = 0;
                default: ;
            endcase
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [2:0] m, input logic [W-1:0] d,
                                 input logic sr, input logic sl, input logic s, input string tag);
        en = e; mode = m; d_in = d; ser_in_r = sr; ser_in_l = sl; start = s;
        modelTick();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    // Asserts rst mid-cycle, checks the immediate effect, then releases it before the next edge.
    task automatic midCycleReset(input string tag);
        #3;
        en = 1'b0; mode = 3'b000; start = 1'b0;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput(tag);
        #2;
        rst = 1'b0;
    endtask

    logic [W-1:0] sweepExp [6] = '{8'hCB, 8'h2D, 8'h4B, 8'h2D, 8'hCB, 8'h00};
    logic [W-1:0] b2Word;

    initial begin
        // Power-on reset.
        rst = 1'b1;
        #2;
        modelReset();
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b0;
        #4;

        // Reset while holding a loaded value.
        applyStimulus(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 1'b0, "load_a5");
        midCycleReset("async_rst");
        idle("post_rst");

        // Mode sweep from 0x96 with both serial fills at 1.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 3'b001, 8'h96, 1'b0, 1'b0, 1'b0, "sweep_load");
            applyStimulus(1'b1, 3'(i + 2), 8'h00, 1'b1, 1'b1, 1'b0, "sweep_op");
            checkValue($sformatf("sweep_const_mode%0d", i + 2), 64'(d_out), 64'(sweepExp[i]));
        end
        applyStimulus(1'b1, 3'b001, 8'h96, 1'b0, 1'b0, 1'b0, "hold_load");
        for (int m = 0; m < 8; m++) begin
            applyStimulus(1'b0, 3'(m), 8'h5A, 1'b1, 1'b1, 1'b0, "en0_hold");
            checkValue("en0_const", 64'(d_out), 64'h96);
        end

        // Directed burst of 0xB2.
        b2Word = 8'b1011_0010;
        applyStimulus(1'b0, 3'b000, 8'hB2, 1'b0, 1'b0, 1'b1, "b2_k0");
        for (int k = 0; k < W; k++) begin
            checkValue($sformatf("b2_stream%0d", k), 64'(ser_out_r), 64'(b2Word[k]));
            checkValue($sformatf("b2_done%0d", k), 64'(done), 64'(k == W - 1 ? 1 : 0));
            checkValue($sformatf("b2_busy%0d", k), 64'(busy), 64'(1));
            if (k < W - 1) idle("b2_step");
        end
        idle("b2_end");
        checkValue("b2_busy_low", 64'(busy), 64'(0));

        // Burst isolation: controls and start toggle every cycle, start held high in the done cycle.
        applyStimulus(1'b1, 3'b111, 8'h6C, 1'b1, 1'b1, 1'b1, "iso_k0");
        for (int k = 1; k < W; k++)
            applyStimulus(1'($urandom), 3'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                          (k == W - 1) ? 1'b1 : 1'($urandom), "iso_step");
        applyStimulus(1'b0, 3'b000, 8'hFF, 1'b0, 1'b0, 1'b1, "iso_end");
        checkValue("iso_no_second", 64'(busy), 64'(0));
        idle("iso_idle");

        // Reset in burst cycle 3, then a full fresh burst.
        applyStimulus(1'b0, 3'b000, 8'hE7, 1'b0, 1'b0, 1'b1, "mb_k0");
        for (int k = 1; k <= 3; k++) idle("mb_step");
        midCycleReset("mb_rst");
        for (int k = 0; k < W + 1; k++) idle("mb_quiet");
        applyStimulus(1'b0, 3'b000, W'($urandom), 1'b0, 1'b0, 1'b1, "mb_restart");
        for (int k = 1; k <= W; k++) idle("mb_full");

        // Random traffic with occasional bursts.
        for (int n = 0; n < 200; n++)
            applyStimulus(1'($urandom), 3'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 15) == 0), "random");
        for (int k = 0; k <= W; k++) idle("drain");

        // Parity values.
        applyStimulus(1'b1, 3'b001, 8'h07, 1'b0, 1'b0, 1'b0, "par_07");
`ifdef USHIFT_PARITY_EN
        checkValue("par_07_const", 64'(parity), 64'(1));
`else
        checkValue("par_07_const", 64'(parity), 64'(0));
`endif
        applyStimulus(1'b1, 3'b001, 8'h03, 1'b0, 1'b0, 1'b0, "par_03");
        checkValue("par_03_const", 64'(parity), 64'(0));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the next generation of the team's parallel-in/parallel-out register. It adds enable, parallel load, logical/arithmetic/rotate shifts in both directions, serial in/out at both ends and an autonomous LSB-first serialise burst with busy/done handshake. It sits between parallel datapaths and bit-serial links, and also serves as a general configurable register stage.

## Interface
- WIDTH, 8: register width in bits; legal range 2 to 64.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  enable for mode operations; ignored during a burst.
- mode  input  3  operation select (see Operation).
- d_in  input  WIDTH  parallel data in.
- ser_in_r  input  1  serial fill bit entering at MSB on a right shift.
- ser_in_l  input  1  serial fill bit entering at LSB on a left shift.
- start  input  1  begin serialise burst; sampled only when idle.
- d_out  output  WIDTH  register contents.
- ser_out_r  output  1  d_out[0], combinational from register.
- ser_out_l  output  1  d_out[WIDTH-1], combinational from register.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse on last burst bit.
- parity  output  1  parity of d_out (see Configuration).

## Operation
- Reset values: d_out=0, busy=0, done=0, internal count=0, FSM=IDLE; ser_out_r/ser_out_l/parity follow at 0.
- FSM states: IDLE, BURST.
- IDLE, start=1: d_out<=d_in, count<=WIDTH-1, busy<=1, go to BURST. start has priority over en/mode in the same cycle.
- IDLE, start=0, en=1, by mode:
  - 000 hold.
  - 001 load: d_out<=d_in.
  - 010 shift right: d_out<={ser_in_r, d_out[WIDTH-1:1]}.
  - 011 shift left: d_out<={d_out[WIDTH-2:0], ser_in_l}.
  - 100 rotate right. 101 rotate left.
  - 110 arithmetic shift right: MSB replicated.
  - 111 clear: d_out<=0.
- IDLE, en=0: hold regardless of mode.
- BURST: each cycle, if count!=0, shift right with 0 fill and decrement count. If count==0, done=1 for this cycle only; next edge busy<=0, go to IDLE, d_out holds its (zero) value.
- During BURST, en, mode and start are ignored. A start asserted in the same cycle done=1 is ignored; a new burst needs start in IDLE.
- Reset mid-burst: immediate return to IDLE with all reset values; no done pulse.

## Timing
- All ops: one-cycle latency; result visible on d_out after the capturing edge.
- Burst: start sampled at edge E0. busy=1 from after E0 through WIDTH cycles. In burst cycle k (k=0..WIDTH-1), ser_out_r = d_in[k] as captured at E0. done=1 in cycle k=WIDTH-1 only. busy=0 after edge E0+WIDTH.
- Back-to-back bursts: minimum start-to-start spacing is WIDTH+1 cycles.
- ser_out_r, ser_out_l and parity are combinational from registers only; no input-to-output combinational paths.

## Configuration
- USHIFT_PARITY_EN defined: parity = XOR reduction of d_out (even-parity bit), combinational from the register.
- Not defined: parity tied to 0; no XOR logic synthesised. Port list is identical in both builds.

## Test plan
- Reset during activity: load 0xA5, assert rst asynchronously mid-cycle -> d_out=0x00, busy=0 immediately, before the next clock edge.
- Mode sweep, WIDTH=8, start at d_out=0x96:
  - shift right, ser_in_r=1 -> 0xCB.
  - shift left, ser_in_l=1 -> 0x2D.
  - rotate right -> 0x4B.
  - rotate left -> 0x2D.
  - arithmetic right -> 0xCB.
  - clear -> 0x00.
  - en=0 with any mode -> holds.
- Burst: start with d_in=0xB2 -> ser_out_r sequence 0,1,0,0,1,1,0,1 over 8 busy cycles; done high only in the 8th; busy low after.
- Burst isolation: toggle en/mode/start throughout a burst, including start in the done cycle -> serial stream unchanged, no second burst.
- Reset mid-burst: rst at burst cycle 3 -> busy=0, done never pulses, d_out=0; next start runs a full burst.
- Parity build: with USHIFT_PARITY_EN, load 0x07 -> parity=1; load 0x03 -> parity=0. Without the macro -> parity=0 for both.
